tlc5615_dac: RTL and testbench
==============================

# tlc5615_dac

Serial transmitter for a TLC5615 10-bit DAC, the output-side counterpart to the board's parallel ADC sampling path. It accepts a 10-bit code over a valid/ready handshake and shifts a 12-bit frame (code MSB first, then two zero fill bits) to the DAC over a 3-wire SPI-style link. The DAC output updates on the rising edge of chip-select. The block sits between control logic (roof actuator or indicator level) and the DAC pins, and runs from the 50 MHz system clock.

## Interface
- CLK_DIV, 25: i_clk cycles per SCLK half-period; the legal minimum is 2. The default gives a 1 MHz SCLK.
- CS_GAP, 25: i_clk cycles that o_dac_cs_n stays high after a frame before a new code is accepted; the legal minimum is 1.
- i_clk  in  1  system clock, 50 MHz.
- i_rst_n  in  1  reset. One clock domain; reset is synchronous and active-low.
- i_data  in  10  DAC code; sampled only on the handshake edge.
- i_valid  in  1  i_data is valid.
- o_ready  out  1  block is idle and can accept a code.
- o_dac_sclk  out  1  DAC serial clock; idles low.
- o_dac_din  out  1  DAC serial data; the DAC samples it on the SCLK rising edge.
- o_dac_cs_n  out  1  DAC chip select, active low.

## Operation
- States:
  - IDLE: o_ready=1, cs_n=1, sclk=0, din=0.
  - SETUP: cs_n=0, sclk=0, din=frame bit 11.
  - SHIFT_HI: sclk=1.
  - SHIFT_LO: sclk=0.
  - GAP: cs_n=1, sclk=0, din=0.
- Handshake: a transfer is accepted on the rising edge where i_valid && o_ready. On that edge:
  - the frame register loads {i_data, 2'b00};
  - the state goes to SETUP;
  - o_ready is 0 from the next cycle.
- i_data and i_valid are ignored while o_ready=0.
- SETUP lasts CLK_DIV cycles, then goes to SHIFT_HI with bit counter = 0.
- SHIFT_HI lasts CLK_DIV cycles, then goes to SHIFT_LO. At that transition, din advances to the next frame bit (MSB-first order); after bit 0 has been sent, din=0.
- SHIFT_LO lasts CLK_DIV cycles. When it ends, the counter increments. If 12 high phases are done, the state goes to GAP and cs_n rises on that edge (the DAC update point); otherwise it goes to SHIFT_HI.
- GAP lasts CS_GAP cycles, then goes to IDLE.
- A back-to-back i_valid is accepted on the first cycle back in IDLE.
- Arithmetic:
  - the phase counter is wide enough for max(CLK_DIV, CS_GAP)-1 and compares against CLK_DIV-1 (or CS_GAP-1);
  - the 4-bit bit counter counts 0..11 and never wraps past 11.
- Reset (i_rst_n=0 at any edge, including mid-frame): next state is IDLE, o_ready=1, cs_n=1, sclk=0, din=0, and counters and frame register are cleared. An aborted frame may update the DAC with partial data; the controller must resend the code after reset.

## Timing
- All outputs are registered, with no combinational path from input to output.
- Reset values: o_ready=1, o_dac_cs_n=1, o_dac_sclk=0, o_dac_din=0.
- Measured from the handshake edge, with N=CLK_DIV:
  - cs_n falls 1 cycle later;
  - the first SCLK rise is at N+1;
  - SCLK rise k (k=0..11) is at N+1+2kN;
  - cs_n rises at 25N+1;
  - o_ready returns at 25N+CS_GAP+1.
- With defaults, the DAC update (cs_n rise) is at cycle 626 and o_ready returns at cycle 651.
- din is stable for N cycles on each side of every SCLK rise.
- SCLK period is 2N cycles. At N=25 it meets the TLC5615 setup, hold and minimum-CS-high requirements with margin.

## Structure
- Package tlc5615_pkg holds:
  - FRAME_BITS=12 and DATA_BITS=10;
  - the state enumeration (IDLE, SETUP, SHIFT_HI, SHIFT_LO, GAP).
- There is one sub-module, dac_phase_timer: a loadable down-counter with a terminal-count pulse, loaded with CLK_DIV-1 or CS_GAP-1 on every state entry.
- The top level holds the FSM, the frame shift register and the bit counter.

## Test plan
- Reset then idle: hold i_rst_n=0 for 3 cycles, then release. Outputs must be o_ready=1, cs_n=1, sclk=0, din=0, with no activity for 1000 cycles.
- Single frame: i_data=10'h2A5 with defaults. The bench samples din on 12 SCLK rises and reads 1010100101_00; cs_n rises at cycle 626 and o_ready returns at cycle 651.
- Boundary codes: 10'h000 must give 12 zeros, and 10'h3FF must give 1111111111_00. Exactly 12 SCLK rises per frame.
- Busy ignore: assert i_valid with 10'h155 at cycle 100 of a 10'h0F0 frame. The 10'h0F0 frame must be unchanged, and 10'h155 is accepted only when o_ready returns (cycle 651).
- Reset mid-frame: drop i_rst_n at cycle 300. On the next edge, cs_n=1, sclk=0, din=0 and o_ready=1; a new 10'h100 frame must then transfer correctly.
- Parameters: with CLK_DIV=2 and CS_GAP=1, the SCLK period is 4 cycles, cs_n rises at cycle 51 and o_ready returns at cycle 52.

Source files
------------

// File: rtl/tlc5615_pkg.sv
// tlc5615_pkg: shared frame sizes, FSM state encoding and a small width helper
// for the TLC5615 serial DAC transmitter.
package tlc5615_pkg;
   localparam int FRAME_BITS = 12;
   localparam int DATA_BITS  = 10;
   typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, GAP} state_t;
   function automatic int max_int(input int a, input int b);
      return a > b ? a : b;
   endfunction
endpackage

// File: rtl/tlc5615_dac_phase_timer.sv
// dac_phase_timer: loadable down-counter whose terminal count marks the last
// cycle of an FSM phase.
// Ports: clk (clock), rst_n (sync active-low reset), load (reload strobe),
//        value (reload value), tc (count has reached zero).
module dac_phase_timer #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         tc
);
   logic [W-1:0] cnt;
   assign tc = cnt == '0;
   always_ff @(posedge clk) begin
      if (!rst_n) cnt <= '0;
      else if (load) cnt <= value;
      else if (!tc) cnt <= cnt - W'(1);
   end
endmodule

// File: rtl/tlc5615_dac.sv
// tlc5615_dac: accepts a 10-bit code on a valid/ready handshake and shifts a
// 12-bit frame (code MSB first, two zero fill bits) to a TLC5615 DAC.
// Ports: i_clk (system clock), i_rst_n (sync active-low reset),
//        i_data/i_valid/o_ready (code handshake),
//        o_dac_sclk/o_dac_din/o_dac_cs_n (registered DAC serial pins).
module tlc5615_dac import tlc5615_pkg::*; #(
   parameter int CLK_DIV = 25,
   parameter int CS_GAP  = 25
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [DATA_BITS-1:0] i_data,
   input  logic                 i_valid,
   output logic                 o_ready,
   output logic                 o_dac_sclk,
   output logic                 o_dac_din,
   output logic                 o_dac_cs_n
);
   localparam int TW = max_int(1, $clog2(max_int(CLK_DIV, CS_GAP)));
   state_t state, nxt;
   logic [FRAME_BITS-1:0] frame;
   logic [3:0] bit_cnt;
   logic tc, accept;
   assign accept = i_valid && o_ready;
   always_comb begin
      nxt = state;
      case (state)
         IDLE:     if (accept) nxt = SETUP;
         SETUP:    if (tc) nxt = SHIFT_HI;
         SHIFT_HI: if (tc) nxt = SHIFT_LO;
         SHIFT_LO: if (tc) nxt = bit_cnt == 4'(FRAME_BITS - 1) ? GAP : SHIFT_HI;
         GAP:      if (tc) nxt = IDLE;
         default:  nxt = IDLE;
      endcase
   end
   // Every transition is a state entry, so the timer reloads on any change.
   dac_phase_timer #(.W(TW)) timer (
      .clk  (i_clk),
      .rst_n(i_rst_n),
      .load (nxt != state),
      .value(nxt == GAP ? TW'(CS_GAP - 1) : TW'(CLK_DIV - 1)),
      .tc   (tc)
   );
   // Pin outputs are registered from the current state, so they trail the
   // state by one cycle; o_ready drops on the handshake edge itself so a
   // second code cannot slip in.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         frame      <= '0;
         bit_cnt    <= '0;
         o_ready    <= 1'b1;
         o_dac_cs_n <= 1'b1;
         o_dac_sclk <= 1'b0;
         o_dac_din  <= 1'b0;
      end else begin
         state <= nxt;
         if (accept) frame <= {i_data, 2'b00};
         else if (state == SHIFT_HI && tc) frame <= frame << 1;
         if (state == SETUP) bit_cnt <= '0;
         else if (state == SHIFT_LO && tc && bit_cnt != 4'(FRAME_BITS - 1)) bit_cnt <= bit_cnt + 4'd1;
         o_ready    <= state == IDLE && !accept;
         o_dac_cs_n <= state == IDLE || state == GAP;
         o_dac_sclk <= state == SHIFT_HI;
         o_dac_din  <= (state == SETUP || state == SHIFT_HI || state == SHIFT_LO) && frame[FRAME_BITS-1];
      end
   end
endmodule

// File: tb/tb_tlc5615_dac.sv
// tb_tlc5615_dac: directed self-checking bench for tlc5615_dac, covering the
// default timing and a CLK_DIV=2 / CS_GAP=1 instance.
module tb_tlc5615_dac;
   logic clk = 0, rst_n = 0, valid = 0, sel = 0;
   logic [9:0] data = '0;
   logic rdy_a, sclk_a, din_a, cs_a, rdy_b, sclk_b, din_b, cs_b;
   logic rdy, sclk, din, cs_n;
   int checks = 0, failures = 0;

   always #10 clk = ~clk;

   tlc5615_dac dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid && !sel),
      .o_ready(rdy_a), .o_dac_sclk(sclk_a), .o_dac_din(din_a), .o_dac_cs_n(cs_a)
   );
   tlc5615_dac #(.CLK_DIV(2), .CS_GAP(1)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid && sel),
      .o_ready(rdy_b), .o_dac_sclk(sclk_b), .o_dac_din(din_b), .o_dac_cs_n(cs_b)
   );

   assign rdy  = sel ? rdy_b  : rdy_a;
   assign sclk = sel ? sclk_b : sclk_a;
   assign din  = sel ? din_b  : din_a;
   assign cs_n = sel ? cs_b   : cs_a;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
      end
   endtask

   // Starts at the negedge before the handshake edge; observes every cycle
   // after it until o_ready returns, then checks frame content and timing.
   task automatic capture(input string tag, input logic [9:0] code, input int n, input int gap,
                          input int inj_c, input logic [9:0] inj);
      logic [11:0] bits;
      int rises, cs_rise, rdy_at, bad_t, bad_s, last_rise, last_chg;
      logic ps, pc, pd;
      bits = '0; rises = 0; cs_rise = 0; rdy_at = 0; bad_t = 0; bad_s = 0;
      last_rise = -1000; last_chg = 0;
      @(posedge clk);
      @(negedge clk);
      valid = 0;
      check({tag, "_ready_drop"}, 32'(rdy), 0);
      check({tag, "_cs_edge0"}, 32'(cs_n), 1);
      ps = sclk; pc = cs_n; pd = din;
      for (int c = 1; c <= 2000 && rdy_at == 0; c++) begin
         if (c == inj_c) begin valid = 1; data = inj; end
         @(negedge clk);
         if (c == 1) check({tag, "_cs_fall"}, 32'(cs_n), 0);
         if (din !== pd) begin
            last_chg = c;
            if (c - last_rise < n) bad_s++;
         end
         if (sclk && !ps) begin
            if (c - last_chg < n) bad_s++;
            if (c != n + 1 + 2 * rises * n) bad_t++;
            if (rises < 12) bits[11 - rises] = din;
            rises++;
            last_rise = c;
         end
         if (cs_n && !pc) cs_rise = c;
         if (rdy) rdy_at = c;
         ps = sclk; pc = cs_n; pd = din;
      end
      check({tag, "_bits"}, 32'(bits), 32'({code, 2'b00}));
      check({tag, "_rises"}, rises, 12);
      check({tag, "_rise_times"}, bad_t, 0);
      check({tag, "_din_stable"}, bad_s, 0);
      check({tag, "_cs_rise"}, cs_rise, 25 * n + 1);
      check({tag, "_ready_back"}, rdy_at, 25 * n + gap + 1);
   endtask

   task automatic send(input string tag, input logic [9:0] code, input int n, input int gap,
                       input int inj_c, input logic [9:0] inj);
      @(negedge clk);
      data = code;
      valid = 1;
      capture(tag, code, n, gap, inj_c, inj);
   endtask

   initial begin
      int act;
      logic ps, pc, pd, pr;
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(rdy), 1);
      check("rst_cs", 32'(cs_n), 1);
      check("rst_sclk", 32'(sclk), 0);
      check("rst_din", 32'(din), 0);
      rst_n = 1;
      act = 0;
      ps = sclk; pc = cs_n; pd = din; pr = rdy;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         if (sclk !== ps || cs_n !== pc || din !== pd || rdy !== pr) act++;
      end
      check("idle_activity", act, 0);

      send("f2a5", 10'h2A5, 25, 25, 0, '0);
      send("f000", 10'h000, 25, 25, 0, '0);
      send("f3ff", 10'h3FF, 25, 25, 0, '0);
      send("f0f0_busy", 10'h0F0, 25, 25, 100, 10'h155);
      capture("f155_after", 10'h155, 25, 25, 0, '0);

      @(negedge clk);
      data = 10'h2A5;
      valid = 1;
      @(posedge clk);
      @(negedge clk);
      valid = 0;
      repeat (299) @(negedge clk);
      check("mid_cs_low", 32'(cs_n), 0);
      rst_n = 0;
      @(negedge clk);
      check("mid_rst_cs", 32'(cs_n), 1);
      check("mid_rst_sclk", 32'(sclk), 0);
      check("mid_rst_din", 32'(din), 0);
      check("mid_rst_ready", 32'(rdy), 1);
      rst_n = 1;
      send("f100", 10'h100, 25, 25, 0, '0);

      @(negedge clk);
      sel = 1;
      send("fast2a5", 10'h2A5, 2, 1, 0, '0);
      send("fast3ff", 10'h3FF, 2, 1, 0, '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
